// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: three one-deep
// producer slots (mem, alu, link) drained round-robin into registered rf_* outputs.
module regfile_wb_arbiter #(
   parameter int DISCARD_R0 = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_dest,
   input  logic [31:0] mem_data,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_dest,
   input  logic [31:0] alu_data,
   input  logic        lnk_valid,
   output logic        lnk_ready,
   input  logic [4:0]  lnk_dest,
   input  logic [31:0] lnk_data,
   output logic        rf_write_enable,
   output logic [4:0]  rf_dest,
   output logic [31:0] rf_alu_data,
   output logic [31:0] rf_mem_data,
   output logic [31:0] rf_pc_addr,
   output logic        rf_mem_sel,
   output logic        rf_pc_sel,
   output logic        busy
);

   logic [2:0]  in_valid;
   logic [4:0]  in_dest [3];
   logic [31:0] in_data [3];

   logic [2:0]  slot_full;
   logic [4:0]  slot_dest [3];
   logic [31:0] slot_data [3];
   logic [2:0]  slot_ready;
   logic [2:0]  grant;
   logic [1:0]  grant_idx;
   logic        any_grant;
   logic [1:0]  last_reg;

   logic        we_reg;
   logic [4:0]  dest_reg,  dest_next;
   logic [31:0] alu_reg,   alu_next;
   logic [31:0] mem_reg,   mem_next;
   logic [31:0] pc_reg,    pc_next;
   logic        msel_reg;
   logic        psel_reg;

   assign in_valid   = {lnk_valid, alu_valid, mem_valid};
   assign in_dest[0] = mem_dest;
   assign in_dest[1] = alu_dest;
   assign in_dest[2] = lnk_dest;
   assign in_data[0] = mem_data;
   assign in_data[1] = alu_data;
   assign in_data[2] = lnk_data;

   // ready depends only on slot state and the pointer, so valid never loops back into it
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gen_slot
         logic        full_reg;
         logic [4:0]  sdest_reg;
         logic [31:0] sdata_reg;
         logic        accept;
         logic        keep;

         assign slot_ready[gi] = !full_reg || grant[gi];
         assign accept         = in_valid[gi] && slot_ready[gi];
         assign keep           = !((DISCARD_R0 != 0) && (in_dest[gi] == 5'd0));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               full_reg  <= 1'b0;
               sdest_reg <= '0;
               sdata_reg <= '0;
            end else if (accept) begin
               full_reg  <= keep;
               sdest_reg <= in_dest[gi];
               sdata_reg <= in_data[gi];
            end else if (grant[gi]) begin
               full_reg  <= 1'b0;
            end
         end

         assign slot_full[gi] = full_reg;
         assign slot_dest[gi] = sdest_reg;
         assign slot_data[gi] = sdata_reg;
      end
   endgenerate

   assign mem_ready = slot_ready[0];
   assign alu_ready = slot_ready[1];
   assign lnk_ready = slot_ready[2];

   // Scan starts just after the last granted source
   always_comb begin
      grant     = '0;
      grant_idx = last_reg;
      case (last_reg)
         2'd0: begin
            if      (slot_full[1]) begin grant[1] = 1'b1; grant_idx = 2'd1; end
            else if (slot_full[2]) begin grant[2] = 1'b1; grant_idx = 2'd2; end
            else if (slot_full[0]) begin grant[0] = 1'b1; grant_idx = 2'd0; end
         end
         2'd1: begin
            if      (slot_full[2]) begin grant[2] = 1'b1; grant_idx = 2'd2; end
            else if (slot_full[0]) begin grant[0] = 1'b1; grant_idx = 2'd0; end
            else if (slot_full[1]) begin grant[1] = 1'b1; grant_idx = 2'd1; end
         end
         default: begin
            if      (slot_full[0]) begin grant[0] = 1'b1; grant_idx = 2'd0; end
            else if (slot_full[1]) begin grant[1] = 1'b1; grant_idx = 2'd1; end
            else if (slot_full[2]) begin grant[2] = 1'b1; grant_idx = 2'd2; end
         end
      endcase
   end

   assign any_grant = |grant;

   always_comb begin
      dest_next = '0;
      alu_next  = '0;
      mem_next  = '0;
      pc_next   = '0;
      if (grant[0]) begin
         dest_next = slot_dest[0];
         mem_next  = slot_data[0];
      end
      if (grant[1]) begin
         dest_next = slot_dest[1];
         alu_next  = slot_data[1];
      end
      if (grant[2]) begin
         dest_next = slot_dest[2];
         pc_next   = slot_data[2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= 2'd2;
         we_reg   <= 1'b0;
         dest_reg <= '0;
         alu_reg  <= '0;
         mem_reg  <= '0;
         pc_reg   <= '0;
         msel_reg <= 1'b0;
         psel_reg <= 1'b0;
      end else begin
         if (any_grant) last_reg <= grant_idx;
         we_reg   <= any_grant;
         dest_reg <= dest_next;
         alu_reg  <= alu_next;
         mem_reg  <= mem_next;
         pc_reg   <= pc_next;
         msel_reg <= grant[0];
         psel_reg <= grant[2];
      end
   end

   assign rf_write_enable = we_reg;
   assign rf_dest         = dest_reg;
   assign rf_alu_data     = alu_reg;
   assign rf_mem_data     = mem_reg;
   assign rf_pc_addr      = pc_reg;
   assign rf_mem_sel      = msel_reg;
   assign rf_pc_sel       = psel_reg;
   assign busy            = (|slot_full) || we_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; a second instance with DISCARD_R0=1
// shares all inputs and is checked in the r0 discard step.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0, alu_valid = 1'b0, lnk_valid = 1'b0;
   logic [4:0]  mem_dest = '0, alu_dest = '0, lnk_dest = '0;
   logic [31:0] mem_data = '0, alu_data = '0, lnk_data = '0;

   logic        mem_ready, alu_ready, lnk_ready;
   logic        rf_write_enable, rf_mem_sel, rf_pc_sel, busy;
   logic [4:0]  rf_dest;
   logic [31:0] rf_alu_data, rf_mem_data, rf_pc_addr;

   logic        d1_mem_ready, d1_alu_ready, d1_lnk_ready;
   logic        d1_rf_write_enable, d1_rf_mem_sel, d1_rf_pc_sel, d1_busy;
   logic [4:0]  d1_rf_dest;
   logic [31:0] d1_rf_alu_data, d1_rf_mem_data, d1_rf_pc_addr;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DISCARD_R0(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
      .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_dest(lnk_dest), .lnk_data(lnk_data),
      .rf_write_enable(rf_write_enable), .rf_dest(rf_dest), .rf_alu_data(rf_alu_data),
      .rf_mem_data(rf_mem_data), .rf_pc_addr(rf_pc_addr), .rf_mem_sel(rf_mem_sel),
      .rf_pc_sel(rf_pc_sel), .busy(busy)
   );

   regfile_wb_arbiter #(.DISCARD_R0(1)) dut_d1 (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_ready(d1_mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(d1_alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
      .lnk_valid(lnk_valid), .lnk_ready(d1_lnk_ready), .lnk_dest(lnk_dest), .lnk_data(lnk_data),
      .rf_write_enable(d1_rf_write_enable), .rf_dest(d1_rf_dest), .rf_alu_data(d1_rf_alu_data),
      .rf_mem_data(d1_rf_mem_data), .rf_pc_addr(d1_rf_pc_addr), .rf_mem_sel(d1_rf_mem_sel),
      .rf_pc_sel(d1_rf_pc_sel), .busy(d1_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic chk_rf(input string tag, input logic we, input logic [4:0] dst,
                         input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                         input logic ms, input logic ps);
      check({tag, ".we"},   rf_write_enable, we);
      check({tag, ".dest"}, rf_dest, dst);
      check({tag, ".alu"},  rf_alu_data, a);
      check({tag, ".mem"},  rf_mem_data, m);
      check({tag, ".pc"},   rf_pc_addr, p);
      check({tag, ".msel"}, rf_mem_sel, ms);
      check({tag, ".psel"}, rf_pc_sel, ps);
      $display("txn %s: we=%0b dest=%0d alu=%h mem=%h pc=%h msel=%0b psel=%0b",
               tag, rf_write_enable, rf_dest, rf_alu_data, rf_mem_data, rf_pc_addr,
               rf_mem_sel, rf_pc_sel);
   endtask

   task automatic chk_ready(input string tag, input logic m, input logic a, input logic l);
      check({tag, ".mem_ready"}, mem_ready, m);
      check({tag, ".alu_ready"}, alu_ready, a);
      check({tag, ".lnk_ready"}, lnk_ready, l);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      lnk_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_alu_q[$];
      logic [31:0] exp_mem_q[$];
      int alu_seq, n_wr, mem_acc_cyc, mem_wr_cyc;
      logic mem_pend;

      // Reset then idle
      #12;
      chk_rf("in_reset", 0, 0, 0, 0, 0, 0, 0);
      check("in_reset.busy", busy, 0);
      chk_ready("in_reset", 1, 1, 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_rf("idle", 0, 0, 0, 0, 0, 0, 0);
      check("idle.busy", busy, 0);
      chk_ready("idle", 1, 1, 1);

      // Single ALU write
      alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'hDEADBEEF;
      check("alu1.ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      check("alu1.busy_pending", busy, 1);
      check("alu1.we_early", rf_write_enable, 0);
      tick();
      chk_rf("alu1.write", 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
      tick();
      chk_rf("alu1.after", 0, 0, 0, 0, 0, 0, 0);
      check("alu1.busy_after", busy, 0);

      // Three simultaneous requests straight after reset
      do_reset();
      mem_valid = 1'b1; mem_dest = 5'd7;  mem_data = 32'h11;
      alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 32'h22;
      lnk_valid = 1'b1; lnk_dest = 5'd31; lnk_data = 32'h33;
      chk_ready("tri.pre", 1, 1, 1);
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0;
      chk_ready("tri.c0", 1, 0, 0);
      tick();
      chk_rf("tri.mem", 1, 7, 0, 32'h11, 0, 1, 0);
      chk_ready("tri.c1", 1, 1, 0);
      tick();
      chk_rf("tri.alu", 1, 20, 32'h22, 0, 0, 0, 0);
      chk_ready("tri.c2", 1, 1, 1);
      tick();
      chk_rf("tri.lnk", 1, 31, 0, 0, 32'h33, 0, 1);
      tick();
      check("tri.idle_we", rf_write_enable, 0);

      // ALU stream with one mem request mid-stream, scoreboarded
      alu_seq = 0; n_wr = 0; mem_acc_cyc = -1; mem_wr_cyc = -1; mem_pend = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (rf_write_enable) begin
            n_wr++;
            if (rf_mem_sel) begin
               mem_wr_cyc = c;
               check("stream.mem_q_nonempty", exp_mem_q.size() != 0, 1);
               if (exp_mem_q.size() != 0) begin
                  check("stream.mem_data", rf_mem_data, exp_mem_q.pop_front());
                  check("stream.mem_dest", rf_dest, 9);
                  check("stream.mem_alu0", rf_alu_data, 0);
               end
            end else begin
               check("stream.alu_q_nonempty", exp_alu_q.size() != 0, 1);
               check("stream.alu_psel", rf_pc_sel, 0);
               if (exp_alu_q.size() != 0) begin
                  check("stream.alu_data", rf_alu_data, exp_alu_q.pop_front());
                  check("stream.alu_dest", rf_dest, 5);
                  check("stream.alu_mem0", rf_mem_data, 0);
               end
            end
            $display("txn stream c=%0d: dest=%0d alu=%h mem=%h msel=%0b",
                     c, rf_dest, rf_alu_data, rf_mem_data, rf_mem_sel);
         end
         alu_valid = (c < 10);
         alu_dest  = 5'd5;
         alu_data  = 32'hA000_0000 + 32'(alu_seq);
         if (c == 4) mem_pend = 1'b1;
         mem_valid = mem_pend;
         mem_dest  = 5'd9;
         mem_data  = 32'h0BEE_F009;
         if (c < 4) check("stream.lone_ready", alu_ready, 1);
         if (alu_valid && alu_ready) begin
            exp_alu_q.push_back(alu_data);
            alu_seq++;
         end
         if (mem_valid && mem_ready) begin
            exp_mem_q.push_back(mem_data);
            mem_acc_cyc = c;
            mem_pend = 1'b0;
         end
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      check("stream.alu_q_drained", exp_alu_q.size(), 0);
      check("stream.mem_q_drained", exp_mem_q.size(), 0);
      check("stream.write_count", n_wr, alu_seq + 1);
      check("stream.mem_seen", mem_wr_cyc >= 0, 1);
      check("stream.mem_wait", (mem_wr_cyc - mem_acc_cyc) <= 3, 1);

      // Link request to r0: dropped by DISCARD_R0=1, written by DISCARD_R0=0
      lnk_valid = 1'b1; lnk_dest = 5'd0; lnk_data = 32'h55;
      check("r0.ready", lnk_ready, 1);
      check("r0.d1_ready", d1_lnk_ready, 1);
      tick();
      lnk_valid = 1'b0;
      check("r0.d1_we0", d1_rf_write_enable, 0);
      check("r0.d1_busy", d1_busy, 0);
      check("r0.busy", busy, 1);
      tick();
      chk_rf("r0.write", 1, 0, 0, 0, 32'h55, 0, 1);
      check("r0.d1_we1", d1_rf_write_enable, 0);
      tick();
      check("r0.d1_we2", d1_rf_write_enable, 0);
      check("r0.we_after", rf_write_enable, 0);

      // Reset while two slots are full
      mem_valid = 1'b1; mem_dest = 5'd2; mem_data = 32'h66;
      alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'h77;
      lnk_valid = 1'b1; lnk_dest = 5'd6; lnk_data = 32'h44;
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0;
      tick();
      check("rstmid.pre_we", rf_write_enable, 1);
      check("rstmid.pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_rf("rstmid.async", 0, 0, 0, 0, 0, 0, 0);
      check("rstmid.busy", busy, 0);
      chk_ready("rstmid", 1, 1, 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rstmid.post_we0", rf_write_enable, 0);
      check("rstmid.post_busy", busy, 0);
      tick();
      check("rstmid.post_we1", rf_write_enable, 0);
      mem_valid = 1'b1; mem_dest = 5'd8; mem_data = 32'h88;
      alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h99;
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      tick();
      chk_rf("rstmid.first", 1, 8, 0, 32'h88, 0, 1, 0);
      tick();
      chk_rf("rstmid.second", 1, 9, 32'h99, 0, 0, 0, 0);
      tick();
      check("rstmid.done_we", rf_write_enable, 0);
      check("rstmid.done_busy", busy, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It collects write requests from three producers: memory load return, ALU result, and PC link (return address). Each producer has its own one-deep holding slot. A round-robin arbiter grants one request per cycle and drives the register file's write-enable, destination, data buses and source-select controls from registers.

## Interface
Parameters:
- DISCARD_R0, 0, when 1 any request with dest 0 is accepted and dropped (never written)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  load write-back request
- mem_ready  out  1  load slot can accept
- mem_dest  in  5  load destination register
- mem_data  in  32  load data
- alu_valid / alu_ready / alu_dest / alu_data  in/out/in/in  1/1/5/32  same, ALU source
- lnk_valid / lnk_ready / lnk_dest / lnk_data  in/out/in/in  1/1/5/32  same, PC-link source
- rf_write_enable  out  1  register file write strobe
- rf_dest  out  5  register file destination
- rf_alu_data  out  32  ALU-path data, valid when ALU granted, else 0
- rf_mem_data  out  32  memory-path data, valid when mem granted, else 0
- rf_pc_addr  out  32  PC-link data, valid when link granted, else 0
- rf_mem_sel  out  1  selects memory data in register file
- rf_pc_sel  out  1  selects PC data in register file
- busy  out  1  any slot full or rf_write_enable high

## Operation
- Source index: 0 = mem, 1 = alu, 2 = lnk.
- Each source has slot state {full, dest[4:0], data[31:0]}.
- x_ready = !full_x || grant_x. grant_x is a function of slot state and pointer only, never of any valid input, so there is no combinational loop.
- Accept when x_valid && x_ready. The slot loads dest/data and full=1.
  - Exception: DISCARD_R0=1 and dest==0. The request is accepted (handshake completes) but full is not set.
- Arbitration:
  - Among full slots, grant the first one found scanning from (last+1) mod 3 upward.
  - At most one grant per cycle.
  - last updates to the granted index. It is unchanged when nothing is granted.
- Same-edge grant and accept on one slot: the new request overwrites the slot, and full stays 1.
- Output registers, loaded every edge:
  - rf_write_enable = any grant.
  - rf_dest = granted dest.
  - The granted data goes on its own bus; the other two buses load 0.
  - rf_mem_sel = grant_0 and rf_pc_sel = grant_2. Both are 0 for an ALU grant or no grant.
- With no grant, all rf_* outputs load 0.
- Ordering between sources follows grant order only. Upstream guarantees that two sources never hold the same dest concurrently. The block does no hazard checks.

## Timing
Reset (async assert on rst_n low, sync release):
- All slots empty.
- last = 2 (mem has first priority).
- All rf_* outputs = 0.
- busy = 0.
- All *_ready = 1.
- Reset mid-operation drops pending slots silently.

Latency:
- Request accepted at edge N.
- Slot granted during cycle N→N+1 if uncontended.
- rf_write_enable high in cycle after edge N+1.
- Register file writes at edge N+2.

Throughput:
- One write per cycle total.
- A lone source streaming with valid held high sustains 1 accept per cycle, with ready held high.

Contention:
- With all three full, the grant order rotates.
- Each source waits at most 2 cycles after becoming full before its grant.

busy is combinational from slot full bits and the rf_write_enable register.

## Test plan
- Reset then idle:
  - Required: all rf_* = 0, busy = 0, all ready = 1.
- Single ALU write (dest 3, data 0xDEADBEEF) at edge N:
  - Required in cycle N+1..N+2: rf_write_enable = 1, rf_dest = 3, rf_alu_data = 0xDEADBEEF, rf_mem_sel = 0, rf_pc_sel = 0.
  - Required after that: outputs return to 0.
- Simultaneous mem (r7 = 0x11), alu (r20 = 0x22) and lnk (r31 = 0x33) right after reset:
  - Required: grants on three consecutive cycles in order mem, alu, lnk, with matching sel bits.
  - Required: ready for alu/lnk stays 0 until their grant cycle.
- Continuous: alu streams valid every cycle and mem requests once mid-stream.
  - Required: the mem write is granted within 2 cycles.
  - Required: alu resumes afterwards, and no request is lost or duplicated (check by scoreboard).
- DISCARD_R0 = 1, lnk request to dest 0:
  - Required: handshake completes and rf_write_enable never asserts.
  - With DISCARD_R0 = 0: the write to r0 appears with rf_pc_sel = 1.
- rst_n asserted while two slots are full:
  - Required: outputs go to 0 immediately.
  - Required: no write is issued after release, and the next request after release is granted with mem-first priority.
